// File: rtl/regfile_pkg.sv
// Shared definitions for the N-read / 1-write register file: the clear-sweep
// state encoding and the depth helper used to size the storage array.
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Number of entries addressed by an address of the given width.
  function automatic int unsigned depthOf(input int unsigned adBit);
    return 32'd1 << adBit;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port of the register file: a priority mux that chooses between the
// forced zero of the clear sweep, the hardwired zero register, the same-cycle
// write bypass and the stored entry.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int AD_BIT   = 5,
  parameter int DATA_BIT = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                busy_i,
  input  logic [AD_BIT-1:0]   addr_i,
  input  logic                we_i,
  input  logic [AD_BIT-1:0]   wAddr_i,
  input  logic [DATA_BIT-1:0] wData_i,
  input  logic [DATA_BIT-1:0] entry_i,
  output logic [DATA_BIT-1:0] rData_o
);

  logic zeroHit;
  logic bypassHit;

  assign zeroHit   = (ZERO_REG != 0) && (addr_i == '0);
  assign bypassHit = (BYPASS != 0) && we_i && (addr_i == wAddr_i);

  // Busy masks everything, then the zero register, then the in-flight write,
  // and only then the array contents.
  always_comb begin
    rData_o = entry_i;
    if (busy_i) begin
      rData_o = '0;
    end else if (zeroHit) begin
      rData_o = '0;
    end else if (bypassHit) begin
      rData_o = wData_i;
    end
  end

endmodule

// File: rtl/regfile_nport.sv
// Parametrised N-read / 1-write register file for the MIPS datapath. Holds the
// storage array, the single write port, and a reset-triggered sweep that
// zeroes one entry per cycle while busy is raised. Read ports are
// combinational and built from regfile_rd_port.
module regfile_nport
  import regfile_pkg::*;
#(
  parameter int AD_BIT   = 5,
  parameter int DATA_BIT = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       WE,
  input  logic [AD_BIT-1:0]          w_AD,
  input  logic [DATA_BIT-1:0]        w_D,
  input  logic [NUM_RD*AD_BIT-1:0]   r_AD,
  output logic [NUM_RD*DATA_BIT-1:0] r_D,
  output logic                       busy
);

  localparam int              DEPTH    = int'(depthOf(AD_BIT));
  localparam logic [AD_BIT:0] CLR_LAST = (AD_BIT+1)'(DEPTH - 1);
  localparam logic [AD_BIT:0] CLR_ONE  = (AD_BIT+1)'(1);

  state_e              state_q;
  state_e              state_d;
  logic [AD_BIT:0]     clrPtr_q;
  logic [AD_BIT:0]     clrPtr_d;
  logic                busy_q;
  logic                busy_d;

  logic [DATA_BIT-1:0] mem_q [DEPTH];

  logic                memWe;
  logic [AD_BIT-1:0]   memAddr;
  logic [DATA_BIT-1:0] memData;
  logic                wrZeroBlocked;

  // Sweep progression: advance the clear pointer each cycle and drop back to
  // IDLE once the last entry has been zeroed. The pointer is one bit wider
  // than an address and stops advancing in IDLE, so it never wraps into a
  // second pass.
  always_comb begin
    state_d  = state_q;
    clrPtr_d = clrPtr_q;
    busy_d   = busy_q;
    if (state_q == ST_CLEAR) begin
      clrPtr_d = clrPtr_q + CLR_ONE;
      if (clrPtr_q == CLR_LAST) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    end
  end

  // Clear FSM state, pointer and registered busy flag. Reset restarts the
  // sweep from entry 0 and holds it there for as long as RST stays high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_CLEAR;
      clrPtr_q <= '0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      clrPtr_q <= clrPtr_d;
      busy_q   <= busy_d;
    end
  end

  assign wrZeroBlocked = (ZERO_REG != 0) && (w_AD == '0);

  // Single write-port arbitration: the sweep owns the array while clearing
  // (user writes are dropped, not queued); in IDLE the user write goes
  // through unless it targets the hardwired zero entry. Nothing is written
  // on a reset edge.
  always_comb begin
    memWe   = 1'b0;
    memAddr = w_AD;
    memData = w_D;
    if (!RST) begin
      if (state_q == ST_CLEAR) begin
        memWe   = 1'b1;
        memAddr = clrPtr_q[AD_BIT-1:0];
        memData = '0;
      end else if (state_q == ST_IDLE) begin
        memWe = WE && !wrZeroBlocked;
      end
    end
  end

  // Storage array; contents are undefined until the first sweep completes.
  always_ff @(posedge CLK) begin
    if (memWe) begin
      mem_q[memAddr] <= memData;
    end
  end

  assign busy = busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AD_BIT-1:0] rAddr;

    assign rAddr = r_AD[k*AD_BIT +: AD_BIT];

    regfile_rd_port #(
      .AD_BIT   (AD_BIT),
      .DATA_BIT (DATA_BIT),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .busy_i   (busy_q),
      .addr_i   (rAddr),
      .we_i     (WE),
      .wAddr_i  (w_AD),
      .wData_i  (w_D),
      .entry_i  (mem_q[rAddr]),
      .rData_o  (r_D[k*DATA_BIT +: DATA_BIT])
    );
  end

endmodule

// File: tb/tb_regfile_nport.sv
// Self-checking bench for regfile_nport. Two instances share clock, reset and
// write port: dutA has 4 read ports with zero register and bypass enabled,
// dutB has 2 read ports (driven by dutA's ports 0 and 1 addresses) with both
// features disabled, so each vector shows the contrasting behaviour.
module tb_regfile_nport;

  logic        CLK;
  logic        RST;
  logic        WE;
  logic [2:0]  wAd;
  logic [7:0]  wD;
  logic [11:0] rAdA;
  logic [5:0]  rAdB;
  logic [31:0] rDA;
  logic [15:0] rDB;
  logic        busyA;
  logic        busyB;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        we;
    logic [2:0]  wad;
    logic [7:0]  wd;
    logic [11:0] rad;
    logic [31:0] expA;
    logic [15:0] expB;
  } vec_t;

  vec_t vecs[$];

  assign rAdB = rAdA[5:0];

  regfile_nport #(
    .AD_BIT(3), .DATA_BIT(8), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)
  ) dutA (
    .CLK(CLK), .RST(RST), .WE(WE), .w_AD(wAd), .w_D(wD),
    .r_AD(rAdA), .r_D(rDA), .busy(busyA)
  );

  regfile_nport #(
    .AD_BIT(3), .DATA_BIT(8), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)
  ) dutB (
    .CLK(CLK), .RST(RST), .WE(WE), .w_AD(wAd), .w_D(wD),
    .r_AD(rAdB), .r_D(rDB), .busy(busyB)
  );

  // Free-running clock, period 10.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [11:0] rad4(input logic [2:0] a0, input logic [2:0] a1,
                                       input logic [2:0] a2, input logic [2:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [31:0] dat4(input logic [7:0] d0, input logic [7:0] d1,
                                       input logic [7:0] d2, input logic [7:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic addRow(input logic we, input logic [2:0] wad, input logic [7:0] wd,
                        input logic [11:0] rad, input logic [31:0] expA,
                        input logic [7:0] eb0, input logic [7:0] eb1);
    vec_t v;
    v.we   = we;
    v.wad  = wad;
    v.wd   = wd;
    v.rad  = rad;
    v.expA = expA;
    v.expB = {eb1, eb0};
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] wad,
                               input logic [7:0] wd, input logic [11:0] rad);
    WE   = we;
    wAd  = wad;
    wD   = wd;
    rAdA = rad;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Counts clock edges until each DUT drops busy, checking reads stay zero
  // while busy. A DUT that never drops busy is reported as -1.
  task automatic countBusy(input string tag);
    int nA = -1;
    int nB = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (busyA) checkOutput($sformatf("%s_rdA_busy%0d", tag, n), rDA, 32'h0);
      if (busyB) checkOutput($sformatf("%s_rdB_busy%0d", tag, n), {16'h0, rDB}, 32'h0);
      if (!busyA && nA < 0) nA = n;
      if (!busyB && nB < 0) nB = n;
      if (nA >= 0 && nB >= 0) break;
    end
    checkOutput($sformatf("%s_busyLenA", tag), nA, 32'd8);
    checkOutput($sformatf("%s_busyLenB", tag), nB, 32'd8);
  endtask

  // Reads every entry through every port with no write in flight.
  task automatic readAllZero(input string tag);
    for (int a = 0; a < 8; a++) begin
      applyStimulus(1'b0, 3'd0, 8'h00, rad4(3'(a), 3'(a), 3'(a), 3'(a)));
      #1;
      checkOutput($sformatf("%s_A_addr%0d", tag, a), rDA, 32'h0);
      checkOutput($sformatf("%s_B_addr%0d", tag, a), {16'h0, rDB}, 32'h0);
    end
  endtask

  // Main sequence: reset sweep, directed vector table, mid-sweep reset.
  initial begin
    RST = 1'b1;
    applyStimulus(1'b0, 3'd0, 8'h00, 12'h000);

    // Table rows: {we, wad, wd, read addrs p0..p3, dutA p0..p3, dutB p0..p1}
    addRow(1, 3'd3, 8'hA5, rad4(3,3,3,3), dat4(8'hA5,8'hA5,8'hA5,8'hA5), 8'h00, 8'h00);
    addRow(0, 3'd0, 8'h00, rad4(3,3,0,0), dat4(8'hA5,8'hA5,8'h00,8'h00), 8'hA5, 8'hA5);
    addRow(1, 3'd5, 8'h3C, rad4(0,5,5,3), dat4(8'h00,8'h3C,8'h3C,8'hA5), 8'h00, 8'h00);
    addRow(0, 3'd0, 8'h00, rad4(5,5,1,7), dat4(8'h3C,8'h3C,8'h00,8'h00), 8'h3C, 8'h3C);
    addRow(1, 3'd0, 8'hFF, rad4(0,0,0,0), dat4(8'h00,8'h00,8'h00,8'h00), 8'h00, 8'h00);
    addRow(0, 3'd0, 8'h00, rad4(0,0,0,0), dat4(8'h00,8'h00,8'h00,8'h00), 8'hFF, 8'hFF);
    addRow(1, 3'd1, 8'h11, rad4(1,1,1,1), dat4(8'h11,8'h11,8'h11,8'h11), 8'h00, 8'h00);
    addRow(1, 3'd2, 8'h22, rad4(2,1,2,1), dat4(8'h22,8'h11,8'h22,8'h11), 8'h00, 8'h11);
    addRow(1, 3'd7, 8'h77, rad4(1,2,1,7), dat4(8'h11,8'h22,8'h11,8'h77), 8'h11, 8'h22);
    addRow(0, 3'd0, 8'h00, rad4(1,2,1,7), dat4(8'h11,8'h22,8'h11,8'h77), 8'h11, 8'h22);
    addRow(1, 3'd3, 8'h5A, rad4(3,3,2,7), dat4(8'h5A,8'h5A,8'h22,8'h77), 8'hA5, 8'hA5);
    addRow(0, 3'd0, 8'h00, rad4(3,0,0,3), dat4(8'h5A,8'h00,8'h00,8'h5A), 8'h5A, 8'hFF);

    // Reset state after the first reset edge.
    @(posedge CLK);
    #1;
    checkOutput("rst_busyA", {31'h0, busyA}, 32'd1);
    checkOutput("rst_busyB", {31'h0, busyB}, 32'd1);
    checkOutput("rst_rdA", rDA, 32'h0);
    checkOutput("rst_rdB", {16'h0, rDB}, 32'h0);

    // Second reset cycle, then release and time the sweep.
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    countBusy("sweep1");
    readAllZero("sweep1");

    // Directed vectors: compare combinational reads before the write edge.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      applyStimulus(vecs[i].we, vecs[i].wad, vecs[i].wd, vecs[i].rad);
      #1;
      checkOutput($sformatf("row%0d_A", i), rDA, vecs[i].expA);
      checkOutput($sformatf("row%0d_B", i), {16'h0, rDB}, {16'h0, vecs[i].expB});
    end

    // Start a sweep with a write pulse held, stop it after four cleared
    // entries, then restart it; the held write must never land.
    @(negedge CLK);
    RST = 1'b1;
    applyStimulus(1'b1, 3'd6, 8'h66, rad4(6,6,6,6));
    @(negedge CLK);
    RST = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      checkOutput($sformatf("midsweep_rdA%0d", c), rDA, 32'h0);
      checkOutput($sformatf("midsweep_busyA%0d", c), {31'h0, busyA}, 32'd1);
    end
    RST = 1'b1;
    applyStimulus(1'b1, 3'd5, 8'hEE, rad4(5,3,7,6));
    @(negedge CLK);
    RST = 1'b0;
    countBusy("sweep2");
    readAllZero("sweep2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
